// File: rtl/generador_operandos_pkg.sv
// Shared types and constants for the operand generator: FSM states, LFSR geometry and default seed.
package gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam int              LFSR_W           = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS      = 16'hB400;
  localparam logic [LFSR_W-1:0] GEN_DEFAULT_SEED = 16'hACE1;

  // Feedback is the XOR of bits 15, 13, 12 and 10, shifted into bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/generador_operandos_if.sv
// Bus between the operand generator (master) and the comparator under test (slave).
// Carries the optional err flag when GEN_EQ_CHECK_EN is defined.
interface generador_operandos_if;

  logic       start;
  logic       q;
  logic [7:0] A;
  logic [7:0] B;
  logic       busy;
  logic       done;
  logic [7:0] gt_count;
`ifdef GEN_EQ_CHECK_EN
  logic       err;
`endif

`ifdef GEN_EQ_CHECK_EN
  modport master (input start, input q, output A, output B, output busy,
                  output done, output gt_count, output err);
  modport slave  (output start, output q, input A, input B, input busy,
                  input done, input gt_count, input err);
`else
  modport master (input start, input q, output A, output B, output busy,
                  output done, output gt_count);
  modport slave  (output start, output q, input A, input B, input busy,
                  input done, input gt_count);
`endif

endinterface

// File: rtl/generador_operandos_gen_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous reload to the seed and single-step advance.
module gen_lfsr16
  import gen_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = GEN_DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_step,
  output logic [LFSR_W-1:0] o_value
);

  // An all-zero state would lock the LFSR, so a zero seed becomes 1.
  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : SEED;

  logic [LFSR_W-1:0] r_lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= SEED_EFF;
    end else if (i_load) begin
      r_lfsr <= SEED_EFF;
    end else if (i_step) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign o_value = r_lfsr;

endmodule

// File: rtl/generador_operandos.sv
// Operand generator: drives NUM_VECT pseudo-random A/B pairs to a comparator and counts q==1.
// Optional build macro GEN_EQ_CHECK_EN adds a sticky err flag comparing q against (A>B).
module generador_operandos
  import gen_pkg::*;
#(
  parameter int                NUM_VECT = 16,
  parameter int                LAT      = 1,
  parameter logic [LFSR_W-1:0] SEED     = GEN_DEFAULT_SEED
) (
  input logic                   clk,
  input logic                   rst_n,
  generador_operandos_if.master bus
);

  localparam logic [2:0] CNT_LAST = 3'(LAT - 1);
  localparam logic [7:0] IDX_LAST = 8'(NUM_VECT - 1);

  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_idx;
  logic [2:0]        r_cnt;
  logic [7:0]        r_a;
  logic [7:0]        r_b;
  logic [7:0]        r_gt;
  logic [LFSR_W-1:0] w_lfsr;
  logic              w_accept;
  logic              w_step;

  assign w_accept = (r_state == ST_IDLE) && bus.start;
  assign w_step   = (r_state == ST_SAMPLE);

  gen_lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_accept),
    .i_step  (w_step),
    .o_value (w_lfsr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (bus.start) w_next = ST_LOAD;
      ST_LOAD:   w_next = (LAT > 1) ? ST_WAIT : ST_SAMPLE;
      ST_WAIT:   if (r_cnt == CNT_LAST) w_next = ST_SAMPLE;
      ST_SAMPLE: w_next = (r_idx == IDX_LAST) ? ST_DONE : ST_LOAD;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (r_state != ST_IDLE);
    bus.done = (r_state == ST_DONE);
  end

  // Operands only change on the LOAD exit edge, so they stay stable for the whole window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_cnt <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_gt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_idx <= '0;
            r_cnt <= '0;
            r_gt  <= '0;
          end
        end
        ST_LOAD: begin
          r_a   <= w_lfsr[15:8];
          r_b   <= w_lfsr[7:0];
          r_cnt <= 3'd1;
        end
        ST_WAIT: begin
          r_cnt <= r_cnt + 3'd1;
        end
        ST_SAMPLE: begin
          r_gt  <= r_gt + {7'd0, bus.q};
          r_idx <= r_idx + 8'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.A        = r_a;
  assign bus.B        = r_b;
  assign bus.gt_count = r_gt;

`ifdef GEN_EQ_CHECK_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if ((r_state == ST_SAMPLE) && (bus.q != (r_a > r_b))) begin
      r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`endif

endmodule

// File: tb/tb_generador_operandos.sv
// Randomized self-checking bench for generador_operandos against an LFSR-sequence reference model.
// Define GEN_EQ_CHECK_EN to also exercise the err flag.
module tb_generador_operandos;

  localparam logic [15:0] BIG_SEED = 16'hACE1;
  localparam int          BIG_NV   = 16;
  localparam int          BIG_LAT  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sStart = 1'b0;

  int passCnt = 0;
  int totalCnt = 0;

  logic [7:0] expA [BIG_NV];
  logic [7:0] expB [BIG_NV];
  logic [7:0] expGt;
  logic [7:0] expGt5;

  always #5 clk = ~clk;

  generador_operandos_if bigIf ();
  generador_operandos_if sIf0 ();
  generador_operandos_if sIf1 ();
  generador_operandos_if sIf2 ();
  generador_operandos_if sIf3 ();

  always @(posedge clk) bigIf.q <= (bigIf.A > bigIf.B);

  assign sIf0.start = sStart;
  assign sIf1.start = sStart;
  assign sIf2.start = sStart;
  assign sIf3.start = sStart;
  assign sIf0.q = (sIf0.A > sIf0.B);
  assign sIf1.q = (sIf1.A > sIf1.B);
  assign sIf2.q = (sIf2.A > sIf2.B);
  assign sIf3.q = (sIf3.A > sIf3.B);

  generador_operandos #(.NUM_VECT(BIG_NV), .LAT(BIG_LAT)) dutBig (
    .clk(clk), .rst_n(rst_n), .bus(bigIf.master));
  generador_operandos #(.NUM_VECT(1), .LAT(1), .SEED(16'h120A)) dutS0 (
    .clk(clk), .rst_n(rst_n), .bus(sIf0.master));
  generador_operandos #(.NUM_VECT(1), .LAT(1), .SEED(16'h0A12)) dutS1 (
    .clk(clk), .rst_n(rst_n), .bus(sIf1.master));
  generador_operandos #(.NUM_VECT(1), .LAT(1), .SEED(16'h2424)) dutS2 (
    .clk(clk), .rst_n(rst_n), .bus(sIf2.master));
  generador_operandos #(.NUM_VECT(1), .LAT(1), .SEED(16'h0000)) dutS3 (
    .clk(clk), .rst_n(rst_n), .bus(sIf3.master));

`ifdef GEN_EQ_CHECK_EN
  generador_operandos_if sIfE ();
  assign sIfE.start = sStart;
  assign sIfE.q = 1'b0;
  generador_operandos #(.NUM_VECT(1), .LAT(1), .SEED(16'h120A)) dutE (
    .clk(clk), .rst_n(rst_n), .bus(sIfE.master));
`endif

  // Reference: the k-th operand pair is the seed advanced k times by the tap rule.
  function automatic logic [15:0] lfsrAfter(input logic [15:0] seed, input int n);
    logic [15:0] v;
    v = (seed == 16'h0000) ? 16'h0001 : seed;
    for (int i = 0; i < n; i++) v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    return v;
  endfunction

  function automatic logic [7:0] gtOver(input logic [15:0] seed, input int n);
    logic [15:0] v;
    int cnt;
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      v = lfsrAfter(seed, k);
      if (v[15:8] > v[7:0]) cnt++;
    end
    return 8'(cnt);
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    totalCnt++;
    if (obs === expv) passCnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, expv);
  endtask

  task automatic checkSmall(input string name, input logic [15:0] seed,
                            input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] gt, input logic dn);
    logic [15:0] v;
    v = lfsrAfter(seed, 0);
    checkOutput({name, "_A"}, 16'(a), 16'(v[15:8]));
    checkOutput({name, "_B"}, 16'(b), 16'(v[7:0]));
    checkOutput({name, "_gt"}, 16'(gt), 16'(gtOver(seed, 1)));
    checkOutput({name, "_done"}, 16'(dn), 16'h1);
  endtask

  // One start pulse to all single-vector instances; done must appear on the third edge.
  task automatic applyStimulus(input int pass);
    sStart = 1'b1;
    @(negedge clk);
    sStart = 1'b0;
    checkOutput("s0_busyLoad", 16'(sIf0.busy), 16'h1);
`ifdef GEN_EQ_CHECK_EN
    if (pass > 0) checkOutput("errClearedOnStart", 16'(sIfE.err), 16'h0);
`endif
    @(negedge clk);
    checkOutput("s0_doneEarly", 16'(sIf0.done), 16'h0);
    @(negedge clk);
    checkSmall("s0", 16'h120A, sIf0.A, sIf0.B, sIf0.gt_count, sIf0.done);
    checkSmall("s1", 16'h0A12, sIf1.A, sIf1.B, sIf1.gt_count, sIf1.done);
    checkSmall("s2", 16'h2424, sIf2.A, sIf2.B, sIf2.gt_count, sIf2.done);
    checkSmall("s3", 16'h0000, sIf3.A, sIf3.B, sIf3.gt_count, sIf3.done);
`ifdef GEN_EQ_CHECK_EN
    checkOutput("errSet", 16'(sIfE.err), 16'h1);
    checkOutput("errGoodQ", 16'(sIf0.err), 16'h0);
`endif
    @(negedge clk);
    checkOutput("s0_donePulse", 16'(sIf0.done), 16'h0);
    checkOutput("s0_idleBusy", 16'(sIf0.busy), 16'h0);
    checkOutput("s0_gtHeld", 16'(sIf0.gt_count), 16'(gtOver(16'h120A, 1)));
    if (pass < 0) checkOutput("neverReached", 16'h0, 16'h1);
  endtask

  task automatic runBig(input bit randomStart);
    int busyCnt;
    int doneCnt;
    int k;
    busyCnt = 0;
    doneCnt = 0;
    bigIf.start = 1'b1;
    @(negedge clk);
    for (int c = 0; c <= BIG_NV * (BIG_LAT + 1); c++) begin
      if (c > 0) begin
        k = (c - 1) / (BIG_LAT + 1);
        checkOutput($sformatf("bigA_v%0d", k), 16'(bigIf.A), 16'(expA[k]));
        checkOutput($sformatf("bigB_v%0d", k), 16'(bigIf.B), 16'(expB[k]));
      end
      if (bigIf.busy && !bigIf.done) busyCnt++;
      if (bigIf.done) doneCnt++;
      bigIf.start = randomStart ? 1'($urandom_range(0, 1)) : 1'b0;
      if (c < BIG_NV * (BIG_LAT + 1)) @(negedge clk);
    end
    checkOutput("bigDone", 16'(bigIf.done), 16'h1);
    checkOutput("bigGt", 16'(bigIf.gt_count), 16'(expGt));
    checkOutput("bigBusyCycles", 16'(busyCnt), 16'(BIG_NV * (BIG_LAT + 1)));
    checkOutput("bigDoneCycles", 16'(doneCnt), 16'h1);
    @(negedge clk);
    bigIf.start = 1'b0;
    checkOutput("bigIdleBusy", 16'(bigIf.busy), 16'h0);
    checkOutput("bigIdleDone", 16'(bigIf.done), 16'h0);
    checkOutput("bigGtHeld", 16'(bigIf.gt_count), 16'(expGt));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_A"}, 16'(bigIf.A), 16'h0);
    checkOutput({tag, "_B"}, 16'(bigIf.B), 16'h0);
    checkOutput({tag, "_busy"}, 16'(bigIf.busy), 16'h0);
    checkOutput({tag, "_done"}, 16'(bigIf.done), 16'h0);
    checkOutput({tag, "_gt"}, 16'(bigIf.gt_count), 16'h0);
  endtask

  initial begin
    logic [15:0] v;
    int waitCnt;
    for (int k = 0; k < BIG_NV; k++) begin
      v = lfsrAfter(BIG_SEED, k);
      expA[k] = v[15:8];
      expB[k] = v[7:0];
    end
    expGt  = gtOver(BIG_SEED, BIG_NV);
    expGt5 = gtOver(BIG_SEED, 5);

    bigIf.start = 1'b0;
    #12;
    checkAllZero("reset");
    checkOutput("resetS0_A", 16'(sIf0.A), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat ($urandom_range(1, 3)) @(negedge clk);

    applyStimulus(0);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    applyStimulus(1);

    runBig(1'b1);
    repeat ($urandom_range(0, 4)) @(negedge clk);

    // Start held high across DONE must launch a second run right after one IDLE cycle.
    bigIf.start = 1'b1;
    repeat (BIG_NV * (BIG_LAT + 1) + 2) @(negedge clk);
    checkOutput("holdIdleBusy", 16'(bigIf.busy), 16'h0);
    checkOutput("holdIdleGt", 16'(bigIf.gt_count), 16'(expGt));
    @(negedge clk);
    checkOutput("holdRestartBusy", 16'(bigIf.busy), 16'h1);
    checkOutput("holdRestartGt", 16'(bigIf.gt_count), 16'h0);
    bigIf.start = 1'b0;
    waitCnt = 0;
    while (!bigIf.done && waitCnt < 200) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("holdDoneSeen", 16'(bigIf.done), 16'h1);
    checkOutput("holdGt", 16'(bigIf.gt_count), 16'(expGt));
    @(negedge clk);

    // Reset asserted in a WAIT cycle of vector 5.
    bigIf.start = 1'b1;
    @(negedge clk);
    bigIf.start = 1'b0;
    repeat (5 * (BIG_LAT + 1) + $urandom_range(1, 2)) @(negedge clk);
    checkOutput("preResetGt", 16'(bigIf.gt_count), 16'(expGt5));
    checkOutput("preResetA", 16'(bigIf.A), 16'(expA[5]));
    rst_n = 1'b0;
    #1;
    checkAllZero("midReset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkAllZero("postReset");
    runBig(1'b0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $display("%0d/%0d checks passed", passCnt, totalCnt + 1);
    $fatal(1, "[TB] timeout");
  end

endmodule
